// File: rtl/vfp_frame_source.sv
// AXI4-Stream video test-pattern source: runtime geometry, frame count and
// pattern latched at start; SOF on tuser, EOL on tlast, honours backpressure.
module vfp_frame_source #(
  parameter int unsigned DATA_WIDTH  = 24,
  parameter int unsigned DIM_BITS    = 12,
  parameter int unsigned FCNT_BITS   = 16,
  parameter int unsigned START_COUNT = 32,
  parameter int unsigned FRAME_GAP   = 16,
  parameter logic [31:0] REVISION    = 32'h09072019
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  stop,
  input  logic [DIM_BITS-1:0]   cfg_width,
  input  logic [DIM_BITS-1:0]   cfg_height,
  input  logic [FCNT_BITS-1:0]  cfg_frames,
  input  logic [1:0]            cfg_mode,
  input  logic [DATA_WIDTH-1:0] cfg_solid,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tuser,
  output logic                  m_axis_tlast,
  output logic                  busy,
  output logic                  frame_done,
  output logic [FCNT_BITS-1:0]  frames_sent,
  output logic                  cfg_err,
  output logic [31:0]           revision
);

  localparam int unsigned CW      = DATA_WIDTH / 3;
  localparam int unsigned CNT_W   = 32;
  localparam logic [CNT_W-1:0] SC_LAST = CNT_W'(START_COUNT) - CNT_W'(1);
  localparam logic [CNT_W-1:0] FG_LAST = CNT_W'(FRAME_GAP) - CNT_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_START_DLY, S_STREAM, S_FGAP} state_t;

  state_t                r_state, w_state_nxt;
  logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
  logic [DIM_BITS-1:0]   r_width, r_height, r_bw;
  logic [FCNT_BITS-1:0]  r_frames;
  logic [1:0]            r_mode;
  logic [DATA_WIDTH-1:0] r_solid;
  logic [DIM_BITS-1:0]   r_x, r_y, r_bcnt;
  logic [2:0]            r_bar;
  logic                  r_stop_pend, w_pend_nxt;
  logic                  r_tvalid, w_tvalid_nxt;
  logic [DATA_WIDTH-1:0] r_tdata;
  logic                  r_tuser, r_tlast;
  logic                  r_busy;
  logic                  r_frame_done, w_done_nxt;
  logic [FCNT_BITS-1:0]  r_frames_sent, w_fs_nxt, w_fs_inc;
  logic                  r_cfg_err, w_err_nxt;
  logic                  w_latch, w_load, w_first, w_hs, w_last_x, w_last_beat;
  logic [DIM_BITS-1:0]   w_nx, w_ny, w_nbcnt, w_width, w_bw_cfg;
  logic [2:0]            w_nbar, w_c;
  logic [CW-1:0]         w_nf;
  logic [1:0]            w_mode;
  logic [DATA_WIDTH-1:0] w_solid, w_pix;
  logic                  w_nuser, w_nlast;

  // In IDLE the first beat is built from the live config (START_COUNT==0 path)
  assign w_width     = (r_state == S_IDLE) ? cfg_width : r_width;
  assign w_mode      = (r_state == S_IDLE) ? cfg_mode  : r_mode;
  assign w_solid     = (r_state == S_IDLE) ? cfg_solid : r_solid;
  assign w_bw_cfg    = ((cfg_width >> 3) == '0) ? DIM_BITS'(1) : (cfg_width >> 3);
  assign w_hs        = r_tvalid & m_axis_tready;
  assign w_last_x    = (r_x == r_width - DIM_BITS'(1));
  assign w_last_beat = w_last_x && (r_y == r_height - DIM_BITS'(1));
  assign w_fs_inc    = r_frames_sent + FCNT_BITS'(1);

  // Next-state and next-beat control
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_pend_nxt   = r_stop_pend | stop;
    w_tvalid_nxt = r_tvalid;
    w_done_nxt   = 1'b0;
    w_fs_nxt     = r_frames_sent;
    w_err_nxt    = 1'b0;
    w_latch      = 1'b0;
    w_load       = 1'b0;
    w_first      = 1'b0;
    w_nx         = r_x;
    w_ny         = r_y;
    w_nbcnt      = r_bcnt;
    w_nbar       = r_bar;
    w_nf         = CW'(r_frames_sent);
    case (r_state)
      S_IDLE: begin
        w_pend_nxt = 1'b0;
        if (start) begin
          if (cfg_width != '0 && cfg_height != '0) begin
            w_latch    = 1'b1;
            w_fs_nxt   = '0;
            w_pend_nxt = stop;
            w_cnt_nxt  = '0;
            if (START_COUNT == 0) begin
              w_state_nxt  = S_STREAM;
              w_tvalid_nxt = 1'b1;
              w_first      = 1'b1;
              w_nf         = '0;
            end else begin
              w_state_nxt = S_START_DLY;
            end
          end else begin
            w_err_nxt = 1'b1;
          end
        end
      end
      S_START_DLY: begin
        if (stop) begin
          w_state_nxt = S_IDLE;
          w_pend_nxt  = 1'b0;
        end else if (r_cnt == SC_LAST) begin
          w_state_nxt  = S_STREAM;
          w_tvalid_nxt = 1'b1;
          w_first      = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_STREAM: begin
        if (w_hs && w_last_beat) begin
          w_done_nxt = 1'b1;
          w_fs_nxt   = w_fs_inc;
          w_cnt_nxt  = '0;
          if ((r_frames != '0 && w_fs_inc == r_frames) || r_stop_pend || stop) begin
            w_state_nxt  = S_IDLE;
            w_tvalid_nxt = 1'b0;
            w_pend_nxt   = 1'b0;
          end else if (FRAME_GAP == 0) begin
            w_first = 1'b1;
            w_nf    = CW'(w_fs_inc);
          end else begin
            w_state_nxt  = S_FGAP;
            w_tvalid_nxt = 1'b0;
          end
        end else if (w_hs) begin
          w_load = 1'b1;
          if (w_last_x) begin
            w_nx    = '0;
            w_ny    = r_y + DIM_BITS'(1);
            w_nbcnt = '0;
            w_nbar  = '0;
          end else begin
            w_nx = r_x + DIM_BITS'(1);
            if (r_bcnt == r_bw - DIM_BITS'(1)) begin
              w_nbcnt = '0;
              w_nbar  = (r_bar == 3'd7) ? 3'd7 : r_bar + 3'd1;
            end else begin
              w_nbcnt = r_bcnt + DIM_BITS'(1);
            end
          end
        end
      end
      S_FGAP: begin
        if (stop) begin
          w_state_nxt = S_IDLE;
          w_pend_nxt  = 1'b0;
        end else if (r_cnt == FG_LAST) begin
          w_state_nxt  = S_STREAM;
          w_tvalid_nxt = 1'b1;
          w_first      = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_first) begin
      w_load  = 1'b1;
      w_nx    = '0;
      w_ny    = '0;
      w_nbcnt = '0;
      w_nbar  = '0;
    end
  end

  // Pattern generator for the beat about to be registered
  always_comb begin
    w_pix   = '0;
    w_c     = 3'd7 - w_nbar;
    w_nuser = (w_nx == '0) && (w_ny == '0);
    w_nlast = (w_nx == w_width - DIM_BITS'(1));
    case (w_mode)
      2'd0:    w_pix = {CW'(w_nx), CW'(w_ny), CW'(w_nx) + CW'(w_ny) + w_nf};
      2'd1:    w_pix = {{CW{w_c[2]}}, {CW{w_c[1]}}, {CW{w_c[0]}}};
      2'd2:    w_pix = w_solid;
      default: w_pix = {DATA_WIDTH{w_nx[4] ^ w_ny[4]}};
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_width       <= '0;
      r_height      <= '0;
      r_bw          <= '0;
      r_frames      <= '0;
      r_mode        <= '0;
      r_solid       <= '0;
      r_x           <= '0;
      r_y           <= '0;
      r_bcnt        <= '0;
      r_bar         <= '0;
      r_stop_pend   <= 1'b0;
      r_tvalid      <= 1'b0;
      r_tdata       <= '0;
      r_tuser       <= 1'b0;
      r_tlast       <= 1'b0;
      r_busy        <= 1'b0;
      r_frame_done  <= 1'b0;
      r_frames_sent <= '0;
      r_cfg_err     <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_stop_pend   <= w_pend_nxt;
      r_tvalid      <= w_tvalid_nxt;
      r_busy        <= (w_state_nxt != S_IDLE);
      r_frame_done  <= w_done_nxt;
      r_frames_sent <= w_fs_nxt;
      r_cfg_err     <= w_err_nxt;
      if (w_latch) begin
        r_width  <= cfg_width;
        r_height <= cfg_height;
        r_frames <= cfg_frames;
        r_mode   <= cfg_mode;
        r_solid  <= cfg_solid;
        r_bw     <= w_bw_cfg;
      end
      if (w_load) begin
        r_x     <= w_nx;
        r_y     <= w_ny;
        r_bcnt  <= w_nbcnt;
        r_bar   <= w_nbar;
        r_tdata <= w_pix;
        r_tuser <= w_nuser;
        r_tlast <= w_nlast;
      end
    end
  end

  assign m_axis_tvalid = r_tvalid;
  assign m_axis_tdata  = r_tdata;
  assign m_axis_tuser  = r_tuser;
  assign m_axis_tlast  = r_tlast;
  assign busy          = r_busy;
  assign frame_done    = r_frame_done;
  assign frames_sent   = r_frames_sent;
  assign cfg_err       = r_cfg_err;
  assign revision      = REVISION;

endmodule
